// File: rtl/mode_sequencer_pkg.sv
// Shared encodings for the watch mode sequencer: FSM states, mode LED patterns
// and the small helpers that map between them.
package mode_sequencer_pkg;

    typedef enum logic [1:0] {
        WATCH     = 2'd0,
        COOK      = 2'd1,
        STOPWATCH = 2'd2,
        ALARM     = 2'd3
    } mode_state_t;

    localparam logic [2:0] LED_WATCH     = 3'b001;
    localparam logic [2:0] LED_COOK      = 3'b010;
    localparam logic [2:0] LED_STOPWATCH = 3'b100;
    localparam logic [2:0] LED_OFF       = 3'b000;

    function automatic mode_state_t next_mode(input mode_state_t s);
        mode_state_t n;
        case (s)
            WATCH:     n = COOK;
            COOK:      n = STOPWATCH;
            default:   n = WATCH;
        endcase
        return n;
    endfunction

    // ALARM blinks the COOK LED in step with the buzzer
    function automatic logic [2:0] led_for(input mode_state_t s, input logic buz);
        logic [2:0] led;
        case (s)
            WATCH:     led = LED_WATCH;
            COOK:      led = LED_COOK;
            STOPWATCH: led = LED_STOPWATCH;
            default:   led = buz ? LED_COOK : LED_OFF;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/mode_sequencer_edge_detector_p.sv
// Registered rising/falling edge detector; p_edge/n_edge are valid the cycle
// after the input is first sampled at its new level.
module edge_detector_p (
    input  logic clk,
    input  logic reset_p,
    input  logic cp,
    output logic p_edge,
    output logic n_edge
);

    logic ff_cur;
    logic ff_old;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            ff_cur <= 1'b0;
            ff_old <= 1'b0;
        end else begin
            ff_cur <= cp;
            ff_old <= ff_cur;
        end
    end

    assign p_edge = ff_cur & ~ff_old;
    assign n_edge = ~ff_cur & ff_old;

endmodule

// File: rtl/mode_sequencer.sv
// Top-level watch controller: shares buttons, display and buzzer among the
// watch, cook_timer and stop_watch functions, with a cook alarm override.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WATCH     | fn buttons drive watch_btn, display shows watch time
// COOK      | fn buttons drive cook_timer, display shows cook time
// STOPWATCH | fn buttons drive stop_watch, display shows stopwatch
// ALARM     | buzzer beeps; ack/timeout clears cook_timer, returns to a mode
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 100_000_000,
    parameter int unsigned BEEP_HALF_PERIOD = 25_000_000,
    parameter int unsigned ALARM_TIMEOUT_S  = 10
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       btn_mode,
    input  logic [2:0] btn_fn,
    input  logic [7:0] watch_min,
    input  logic [7:0] watch_sec,
    input  logic [7:0] cook_min,
    input  logic [7:0] cook_sec,
    input  logic       cook_alarm,
    input  logic [7:0] sw_sec,
    input  logic [7:0] sw_csec,
    output logic [2:0] watch_btn,
    output logic       cook_start_pause,
    output logic       cook_add_30s,
    output logic       cook_clear,
    output logic       sw_start,
    output logic       sw_lap_btn,
    output logic       sw_clear,
    output logic [7:0] disp_hi,
    output logic [7:0] disp_lo,
    output logic [2:0] mode_led,
    output logic       buzzer
);

    localparam int PRE_W  = ($clog2(CLK_HZ) < 1)           ? 1 : $clog2(CLK_HZ);
    localparam int BEEP_W = ($clog2(BEEP_HALF_PERIOD) < 1) ? 1 : $clog2(BEEP_HALF_PERIOD);
    localparam int SEC_W  = ($clog2(ALARM_TIMEOUT_S) < 1)  ? 1 : $clog2(ALARM_TIMEOUT_S);

    localparam logic [PRE_W-1:0]  PRE_TC  = PRE_W'(CLK_HZ - 1);
    localparam logic [BEEP_W-1:0] BEEP_TC = BEEP_W'(BEEP_HALF_PERIOD - 1);
    localparam logic [SEC_W-1:0]  SEC_TC  = SEC_W'(ALARM_TIMEOUT_S - 1);

    logic       mode_rise;
    logic       alarm_rise;
    logic       alarm_fall;
    logic [2:0] fn_rise;
    logic [3:0] unused_btn_fall;

    edge_detector_p u_ed_mode (
        .clk     (clk),
        .reset_p (reset_p),
        .cp      (btn_mode),
        .p_edge  (mode_rise),
        .n_edge  (unused_btn_fall[3])
    );

    for (genvar i = 0; i < 3; i++) begin : g_fn_ed
        edge_detector_p u_ed_fn (
            .clk     (clk),
            .reset_p (reset_p),
            .cp      (btn_fn[i]),
            .p_edge  (fn_rise[i]),
            .n_edge  (unused_btn_fall[i])
        );
    end

    edge_detector_p u_ed_alarm (
        .clk     (clk),
        .reset_p (reset_p),
        .cp      (cook_alarm),
        .p_edge  (alarm_rise),
        .n_edge  (alarm_fall)
    );

    mode_state_t state, state_next, ret_mode;

    logic [PRE_W-1:0]  pre_cnt;
    logic [BEEP_W-1:0] beep_cnt;
    logic [SEC_W-1:0]  sec_cnt;
    logic              beep_tc;
    logic              pre_tc;
    logic              timeout;

    assign beep_tc = (beep_cnt == BEEP_TC);
    assign pre_tc  = (pre_cnt == PRE_TC);
    assign timeout = (state == ALARM) && pre_tc && (sec_cnt == SEC_TC);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state <= WATCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ALARM: begin
                if (alarm_fall)     state_next = ret_mode;
                else if (mode_rise) state_next = ret_mode;
                else if (|fn_rise)  state_next = COOK;
                else if (timeout)   state_next = ret_mode;
            end
            default: begin
                if (alarm_rise)     state_next = ALARM;
                else if (mode_rise) state_next = next_mode(state);
            end
        endcase
    end

    logic [2:0] watch_btn_n;
    logic       cook_start_pause_n, cook_add_30s_n, cook_clear_n;
    logic       sw_start_n, sw_lap_btn_n, sw_clear_n;
    logic       buzzer_n;
    logic [2:0] mode_led_n;

    always_comb begin
        watch_btn_n        = 3'b000;
        cook_start_pause_n = 1'b0;
        cook_add_30s_n     = 1'b0;
        cook_clear_n       = 1'b0;
        sw_start_n         = 1'b0;
        sw_lap_btn_n       = 1'b0;
        sw_clear_n         = 1'b0;
        buzzer_n           = buzzer;
        case (state)
            ALARM: begin
                if (alarm_fall) begin
                    buzzer_n = 1'b0;
                end else if (mode_rise || (|fn_rise) || timeout) begin
                    cook_clear_n = 1'b1;
                    buzzer_n     = 1'b0;
                end else if (beep_tc) begin
                    buzzer_n = ~buzzer;
                end
            end
            default: begin
                buzzer_n = 1'b0;
                if (alarm_rise) begin
                    buzzer_n = 1'b1;
                end else if (!mode_rise) begin
                    case (state)
                        WATCH: watch_btn_n = fn_rise;
                        COOK: begin
                            cook_start_pause_n = fn_rise[0];
                            cook_add_30s_n     = fn_rise[1];
                            cook_clear_n       = fn_rise[2];
                        end
                        STOPWATCH: begin
                            sw_start_n   = fn_rise[0];
                            sw_lap_btn_n = fn_rise[1];
                            sw_clear_n   = fn_rise[2];
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        mode_led_n = led_for(state_next, buzzer_n);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            watch_btn        <= 3'b000;
            cook_start_pause <= 1'b0;
            cook_add_30s     <= 1'b0;
            cook_clear       <= 1'b0;
            sw_start         <= 1'b0;
            sw_lap_btn       <= 1'b0;
            sw_clear         <= 1'b0;
            buzzer           <= 1'b0;
            mode_led         <= LED_WATCH;
        end else begin
            watch_btn        <= watch_btn_n;
            cook_start_pause <= cook_start_pause_n;
            cook_add_30s     <= cook_add_30s_n;
            cook_clear       <= cook_clear_n;
            sw_start         <= sw_start_n;
            sw_lap_btn       <= sw_lap_btn_n;
            sw_clear         <= sw_clear_n;
            buzzer           <= buzzer_n;
            mode_led         <= mode_led_n;
        end
    end

    // Counters sit at zero outside ALARM, so every ALARM entry starts fresh
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            pre_cnt  <= '0;
            beep_cnt <= '0;
            sec_cnt  <= '0;
            ret_mode <= WATCH;
        end else if (state != ALARM) begin
            pre_cnt  <= '0;
            beep_cnt <= '0;
            sec_cnt  <= '0;
            if (alarm_rise) ret_mode <= state;
        end else begin
            beep_cnt <= beep_tc ? '0 : beep_cnt + 1'b1;
            pre_cnt  <= pre_tc ? '0 : pre_cnt + 1'b1;
            if (pre_tc) sec_cnt <= (sec_cnt == SEC_TC) ? '0 : sec_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            disp_hi <= 8'd0;
            disp_lo <= 8'd0;
        end else begin
            case (state)
                WATCH: begin
                    disp_hi <= watch_min;
                    disp_lo <= watch_sec;
                end
                STOPWATCH: begin
                    disp_hi <= sw_sec;
                    disp_lo <= sw_csec;
                end
                default: begin
                    disp_hi <= cook_min;
                    disp_lo <= cook_sec;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with shortened alarm timing
// (CLK_HZ=100, BEEP_HALF_PERIOD=4, ALARM_TIMEOUT_S=3).
module tb_mode_sequencer;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       btn_mode;
    logic [2:0] btn_fn;
    logic [7:0] watch_min, watch_sec, cook_min, cook_sec, sw_sec, sw_csec;
    logic       cook_alarm;
    logic [2:0] watch_btn;
    logic       cook_start_pause, cook_add_30s, cook_clear;
    logic       sw_start, sw_lap_btn, sw_clear;
    logic [7:0] disp_hi, disp_lo;
    logic [2:0] mode_led;
    logic       buzzer;

    int n_checks = 0;
    int n_fail   = 0;

    mode_sequencer #(
        .CLK_HZ           (100),
        .BEEP_HALF_PERIOD (4),
        .ALARM_TIMEOUT_S  (3)
    ) dut (
        .clk              (clk),
        .reset_p          (reset_p),
        .btn_mode         (btn_mode),
        .btn_fn           (btn_fn),
        .watch_min        (watch_min),
        .watch_sec        (watch_sec),
        .cook_min         (cook_min),
        .cook_sec         (cook_sec),
        .cook_alarm       (cook_alarm),
        .sw_sec           (sw_sec),
        .sw_csec          (sw_csec),
        .watch_btn        (watch_btn),
        .cook_start_pause (cook_start_pause),
        .cook_add_30s     (cook_add_30s),
        .cook_clear       (cook_clear),
        .sw_start         (sw_start),
        .sw_lap_btn       (sw_lap_btn),
        .sw_clear         (sw_clear),
        .disp_hi          (disp_hi),
        .disp_lo          (disp_lo),
        .mode_led         (mode_led),
        .buzzer           (buzzer)
    );

    always #5 clk = ~clk;

    logic [8:0] pulses;
    assign pulses = {watch_btn, cook_start_pause, cook_add_30s, cook_clear,
                     sw_start, sw_lap_btn, sw_clear};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode(input string tag, input logic [2:0] exp_led,
                              input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        btn_mode = 1'b1;
        tick();
        tick();
        check_eq({tag, "_led"}, 32'(mode_led), 32'(exp_led));
        tick();
        check_eq({tag, "_disp_hi"}, 32'(disp_hi), 32'(exp_hi));
        check_eq({tag, "_disp_lo"}, 32'(disp_lo), 32'(exp_lo));
        btn_mode = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int clear_at;
        int n_start;
        int n_clear;
        logic [8:0] other;
        logic [2:0] led0;

        reset_p    = 1'b1;
        btn_mode   = 1'b0;
        btn_fn     = 3'b000;
        cook_alarm = 1'b0;
        watch_min  = 8'd12; watch_sec = 8'd34;
        cook_min   = 8'd5;  cook_sec  = 8'd30;
        sw_sec     = 8'd7;  sw_csec   = 8'd55;

        // 1. reset state and pulse latency
        tick(); tick(); tick();
        check_eq("rst_led", 32'(mode_led), 32'h1);
        check_eq("rst_buzzer", 32'(buzzer), 32'h0);
        check_eq("rst_pulses", 32'(pulses), 32'h0);
        check_eq("rst_disp", 32'({disp_hi, disp_lo}), 32'h0);
        reset_p = 1'b0;
        btn_fn[1] = 1'b1;
        tick();
        check_eq("wbtn_early", 32'(watch_btn), 32'h0);
        tick();
        check_eq("wbtn_pulse", 32'(watch_btn), 32'h2);
        tick();
        check_eq("wbtn_one_cycle", 32'(watch_btn), 32'h0);
        btn_fn[1] = 1'b0;
        tick(); tick();

        // 2. mode stepping and display mux
        press_mode("to_cook", 3'b010, 8'd5, 8'd30);
        press_mode("to_sw", 3'b100, 8'd7, 8'd55);
        press_mode("to_watch", 3'b001, 8'd12, 8'd34);
        press_mode("to_cook2", 3'b010, 8'd5, 8'd30);
        press_mode("to_sw2", 3'b100, 8'd7, 8'd55);

        // 3. held fn0 in STOPWATCH gives a single sw_start
        btn_fn[0] = 1'b1;
        n_start = 0;
        other = '0;
        for (int i = 0; i < 22; i++) begin
            tick();
            n_start += int'(sw_start);
            other |= (pulses & 9'b111_111_011);
        end
        check_eq("sw_start_count", 32'(n_start), 32'd1);
        check_eq("sw_hold_others", 32'(other), 32'h0);
        btn_fn[0] = 1'b0;
        tick(); tick();

        // 4. alarm from STOPWATCH, beep pattern, timeout
        cook_alarm = 1'b1;
        tick();
        check_eq("alarm_buz_early", 32'(buzzer), 32'h0);
        tick();
        check_eq("alarm_buz_k0", 32'(buzzer), 32'h1);
        check_eq("alarm_led_on", 32'(mode_led), 32'h2);
        check_eq("alarm_disp_prev", 32'(disp_hi), 32'd7);
        clear_at = -1;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (k < 8)
                check_eq($sformatf("alarm_buz_k%0d", k), 32'(buzzer),
                         (((k / 4) % 2) == 0) ? 32'h1 : 32'h0);
            if (k == 1)
                check_eq("alarm_disp_cook", 32'({disp_hi, disp_lo}), {16'h0, 8'd5, 8'd30});
            if (k == 5)
                check_eq("alarm_led_off", 32'(mode_led), 32'h0);
            if (cook_clear) begin
                clear_at = k;
                break;
            end
        end
        check_eq("timeout_cycles", 32'(clear_at), 32'd300);
        check_eq("timeout_led", 32'(mode_led), 32'h4);
        check_eq("timeout_buzzer", 32'(buzzer), 32'h0);
        tick();
        check_eq("timeout_one_clear", 32'(cook_clear), 32'h0);
        cook_alarm = 1'b0;
        tick(); tick();

        // 5. fn2 acknowledge goes to COOK
        cook_alarm = 1'b1;
        tick(); tick();
        check_eq("ack_in_alarm_buz", 32'(buzzer), 32'h1);
        btn_fn[2] = 1'b1;
        tick(); tick();
        check_eq("ack_clear", 32'(cook_clear), 32'h1);
        check_eq("ack_led", 32'(mode_led), 32'h2);
        check_eq("ack_buzzer", 32'(buzzer), 32'h0);
        n_clear = 0;
        other = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_clear += int'(cook_clear);
            other[0] = other[0] | buzzer;
            if (mode_led != 3'b010) other[1] = 1'b1;
        end
        check_eq("ack_no_second_clear", 32'(n_clear), 32'd0);
        check_eq("ack_stays_cook", 32'(other), 32'h0);
        btn_fn[2] = 1'b0;
        cook_alarm = 1'b0;
        tick(); tick();

        // 6. same-cycle priorities
        btn_mode = 1'b1;
        btn_fn[0] = 1'b1;
        tick(); tick();
        check_eq("mode_fn_led", 32'(mode_led), 32'h4);
        check_eq("mode_fn_no_pulse", 32'(pulses), 32'h0);
        tick();
        check_eq("mode_fn_no_pulse_late", 32'(pulses), 32'h0);
        btn_mode = 1'b0;
        btn_fn[0] = 1'b0;
        tick(); tick();

        cook_alarm = 1'b1;
        btn_mode = 1'b1;
        tick(); tick();
        check_eq("alarm_mode_buzzer", 32'(buzzer), 32'h1);
        check_eq("alarm_mode_led", 32'(mode_led), 32'h2);
        btn_mode = 1'b0;
        tick();
        cook_alarm = 1'b0;
        n_clear = 0;
        tick();
        n_clear += int'(cook_clear);
        tick();
        n_clear += int'(cook_clear);
        check_eq("fall_ret_led", 32'(mode_led), 32'h4);
        check_eq("fall_buzzer", 32'(buzzer), 32'h0);
        check_eq("fall_no_clear", 32'(n_clear), 32'd0);
        tick(); tick();

        // reset during ALARM silences the buzzer immediately
        cook_alarm = 1'b1;
        tick(); tick();
        led0 = mode_led;
        check_eq("pre_reset_led", 32'(led0), 32'h2);
        #2;
        reset_p = 1'b1;
        #1;
        check_eq("async_rst_buzzer", 32'(buzzer), 32'h0);
        check_eq("async_rst_led", 32'(mode_led), 32'h1);
        tick();
        reset_p = 1'b0;
        cook_alarm = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
